// File: rtl/audio_mixer.sv
// Three-state (IDLE/ACC/OUT) stereo mixer: snapshots NCH channels and per-channel gains on tick,
// accumulates one channel per clock, then saturates acc>>4. Optional sticky clip output: AUDIO_MIXER_CLIP_EN.
module audio_mixer #(
  parameter  int NCH = 3,
  parameter  int W   = 8,
  parameter  int OW  = 8,
  localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [NCH*W-1:0] ch_in,
  input  logic             cfg_wr,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [7:0]       cfg_data,
  output logic [OW-1:0]    audio_l,
  output logic [OW-1:0]    audio_r,
  output logic             audio_valid,
  output logic             busy
`ifdef AUDIO_MIXER_CLIP_EN
  ,
  output logic             clip
`endif
);

  localparam int CW   = $clog2(NCH + 1);
  localparam int ACCW = W + 4 + CW;
  localparam int XW   = (ACCW > OW) ? ACCW : OW + 1;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e                state_q;
  logic [NCH-1:0][W-1:0] snap_q;
  logic [3:0]            gl_q  [NCH];
  logic [3:0]            gr_q  [NCH];
  logic [3:0]            gls_q [NCH];
  logic [3:0]            grs_q [NCH];
  logic [AW-1:0]         idx_q;
  logic [ACCW-1:0]       accl_q, accr_q;
  logic [ACCW-1:0]       prod_l, prod_r;
  logic [XW-1:0]         shl, shr, omax;
  logic                  sat_l, sat_r;
  logic [OW-1:0]         audio_l_q, audio_r_q;
  logic                  valid_q, busy_q;

  // Live gain registers; one block per channel so reset defaults stay constant per index
  for (genvar g = 0; g < NCH; g++) begin : g_gain
    localparam logic [3:0] GL_RST = (g == 0) ? 4'd8 : (g == 1) ? 4'd4 : 4'd0;
    localparam logic [3:0] GR_RST = (g == 1) ? 4'd4 : (g == 2) ? 4'd8 : 4'd0;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        gl_q[g] <= GL_RST;
        gr_q[g] <= GR_RST;
      end else if (cfg_wr && (cfg_addr == AW'(g))) begin
        gl_q[g] <= cfg_data[7:4];
        gr_q[g] <= cfg_data[3:0];
      end
    end
  end

  always_comb begin
    prod_l = ACCW'(snap_q[idx_q]) * ACCW'(gls_q[idx_q]);
    prod_r = ACCW'(snap_q[idx_q]) * ACCW'(grs_q[idx_q]);
    shl    = XW'(accl_q >> 4);
    shr    = XW'(accr_q >> 4);
    omax   = '0;
    omax[OW-1:0] = '1;
    sat_l  = shl > omax;
    sat_r  = shr > omax;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      gls_q     <= '{default: '0};
      grs_q     <= '{default: '0};
      idx_q     <= '0;
      accl_q    <= '0;
      accr_q    <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            snap_q  <= ch_in;
            gls_q   <= gl_q;
            grs_q   <= gr_q;
            accl_q  <= '0;
            accr_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACC;
          end
        end
        ACC: begin
          accl_q <= accl_q + prod_l;
          accr_q <= accr_q + prod_r;
          idx_q  <= idx_q + AW'(1);
          if (idx_q == AW'(NCH - 1)) state_q <= OUT;
        end
        OUT: begin
          audio_l_q <= sat_l ? '1 : shl[OW-1:0];
          audio_r_q <= sat_r ? '1 : shr[OW-1:0];
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign audio_l     = audio_l_q;
  assign audio_r     = audio_r_q;
  assign audio_valid = valid_q;
  assign busy        = busy_q;

`ifdef AUDIO_MIXER_CLIP_EN
  logic clip_q;

  // Saturation in OUT takes priority over a coincident configuration write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_q <= 1'b0;
    end else if ((state_q == OUT) && (sat_l || sat_r)) begin
      clip_q <= 1'b1;
    end else if (cfg_wr) begin
      clip_q <= 1'b0;
    end
  end

  assign clip = clip_q;
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer (NCH=3, W=OW=8); covers clip output when AUDIO_MIXER_CLIP_EN is defined.
module tb_audio_mixer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [23:0] ch_in;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [7:0]  audio_l, audio_r;
  logic        audio_valid, busy;
`ifdef AUDIO_MIXER_CLIP_EN
  logic        clip;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  audio_mixer #(.NCH(3), .W(8), .OW(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .ch_in      (ch_in),
    .cfg_wr     (cfg_wr),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .audio_valid(audio_valid),
    .busy       (busy)
`ifdef AUDIO_MIXER_CLIP_EN
    ,
    .clip       (clip)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // wr_at: edge offset from the tick edge at which cfg_wr is sampled (-1 = no write)
  task automatic frame(input string tag, input logic [23:0] ch, input int wr_at,
                       input logic [1:0] a, input logic [7:0] d,
                       input logic [7:0] el, input logic [7:0] er);
    int lat;
    @(negedge clk);
    ch_in = ch; tick = 1'b1;
    cfg_wr = (wr_at == 0); cfg_addr = a; cfg_data = d;
    lat = -1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      tick   = 1'b0;
      cfg_wr = (wr_at == lat + 1);
      if (lat == 0) begin
        ch_in = ~ch;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
      if (audio_valid) break;
    end
    cfg_wr = 1'b0;
    chk({tag, "_lat"}, lat, 32'd4);
    chk({tag, "_l"}, {24'd0, audio_l}, {24'd0, el});
    chk({tag, "_r"}, {24'd0, audio_r}, {24'd0, er});
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, busy, audio_valid}, 32'd0);
  endtask

  initial begin
    int cnt;
    reset_n = 1'b1; tick = 1'b0; cfg_wr = 1'b0;
    cfg_addr = '0; cfg_data = '0; ch_in = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_l", {24'd0, audio_l}, 32'd0);
    chk("rst_r", {24'd0, audio_r}, 32'd0);
    chk("rst_vb", {30'd0, audio_valid, busy}, 32'd0);
`ifdef AUDIO_MIXER_CLIP_EN
    chk("rst_clip", {31'd0, clip}, 32'd0);
`endif
    @(negedge clk) reset_n = 1'b1;

    // ch0=FF ch1=40 ch2=80: L=(FF*8+40*4)>>4=8F, R=(40*4+80*8)>>4=50
    frame("base", 24'h8040FF, -1, 2'd0, 8'h00, 8'h8F, 8'h50);
    repeat (5) @(negedge clk);
    chk("hold_l", {24'd0, audio_l}, 32'h8F);
    chk("hold_r", {24'd0, audio_r}, 32'h50);

    cfg_write(2'd3, 8'h00);
    frame("badaddr", 24'h8040FF, -1, 2'd0, 8'h00, 8'h8F, 8'h50);

    // Overlap: extra ticks at k+2 (ACC) and k+4 (OUT) must be ignored
    @(negedge clk); ch_in = 24'h002010; tick = 1'b1;
    @(negedge clk); tick = 1'b0; ch_in = 24'hFFFFFF;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("ovl_valid", {31'd0, audio_valid}, 32'd1);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (audio_valid) cnt++;
    end
    chk("ovl_extra", cnt, 32'd0);
    chk("ovl_l", {24'd0, audio_l}, 32'h10);
    chk("ovl_r", {24'd0, audio_r}, 32'h08);
    chk("ovl_busy", {31'd0, busy}, 32'd0);

    // ch0=ch1=40: default gains give 30/10; ch0 gains 0/F give 10/4C
    frame("midcfg", 24'h004040, 1, 2'd0, 8'h0F, 8'h30, 8'h10);
    frame("next", 24'h004040, -1, 2'd0, 8'h00, 8'h10, 8'h4C);
    frame("coinc", 24'h004040, 0, 2'd0, 8'h80, 8'h10, 8'h4C);
    frame("restored", 24'h004040, -1, 2'd0, 8'h00, 8'h30, 8'h10);

    cfg_write(2'd0, 8'hFF);
    cfg_write(2'd1, 8'hFF);
    cfg_write(2'd2, 8'hFF);
    frame("sat", 24'hFFFFFF, 4, 2'd3, 8'h00, 8'hFF, 8'hFF);
`ifdef AUDIO_MIXER_CLIP_EN
    chk("clip_set", {31'd0, clip}, 32'd1);
    cfg_write(2'd3, 8'h00);
    chk("clip_clr", {31'd0, clip}, 32'd0);
`endif

    // Reset during second ACC cycle aborts the frame
    @(negedge clk); ch_in = 24'h8040FF; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("abort_l", {24'd0, audio_l}, 32'd0);
    chk("abort_r", {24'd0, audio_r}, 32'd0);
    chk("abort_vb", {30'd0, audio_valid, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (audio_valid) cnt++;
    end
    chk("abort_novalid", cnt, 32'd0);
    frame("postrst", 24'h8040FF, -1, 2'd0, 8'h00, 8'h8F, 8'h50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 Parameter NCH, default 3: number of unsigned input channels, legal range 1..16.
REQ-002 Parameter W, default 8: input sample width per channel.
REQ-003 Parameter OW, default 8: output sample width per side.
REQ-004 Derived AW = max(1, ceil(log2(NCH))): configuration address width.
REQ-005 clk  input  1  system clock; the block uses this one clock only.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 tick  input  1  sample strobe, one clk cycle wide.
REQ-008 ch_in  input  NCH*W  channel samples; channel i occupies bits [i*W+W-1 : i*W].
REQ-009 cfg_wr  input  1  configuration write strobe.
REQ-010 cfg_addr  input  AW  channel index to write.
REQ-011 cfg_data  input  8  gain value: [7:4] = left gain GL, [3:0] = right gain GR, each 0..15.
REQ-012 audio_l  output  OW  mixed left sample.
REQ-013 audio_r  output  OW  mixed right sample.
REQ-014 audio_valid  output  1  one-cycle pulse when audio_l and audio_r update.
REQ-015 busy  output  1  high while a mix frame is in progress.

Function
REQ-016 The state machine SHALL have three states: IDLE, ACC and OUT.
REQ-017 In IDLE, when tick=1 the block SHALL snapshot ch_in and all gain registers, clear both accumulators, set idx=0, assert busy and enter ACC.
REQ-018 ACC SHALL add snap[idx]*GL[idx] to acc_l and snap[idx]*GR[idx] to acc_r on each clk.
REQ-019 ACC SHALL increment idx each cycle and enter OUT after idx=NCH-1, so it lasts exactly NCH cycles.
REQ-020 Accumulators SHALL be W+4+ceil(log2(NCH+1)) bits wide and unsigned, and SHALL never overflow.
REQ-021 In OUT the block SHALL load audio_x with acc_x>>4, saturated to 2^OW-1.
REQ-022 In OUT the block SHALL pulse audio_valid for one cycle, deassert busy and return to IDLE.
REQ-023 Latency: if tick is sampled at edge k, audio_valid SHALL be high during the cycle after edge k+NCH+1.
REQ-024 audio_l and audio_r SHALL hold their value between frames.
REQ-025 A tick arriving while busy=1, including in the OUT cycle, SHALL be ignored without side effects.
REQ-026 A cfg_wr with cfg_addr < NCH SHALL update that channel's gains on the next edge.
REQ-027 A cfg_wr with cfg_addr >= NCH SHALL be ignored.
REQ-028 A cfg_wr during a frame SHALL NOT affect that frame; it SHALL take effect from the next snapshot.
REQ-029 When cfg_wr and tick coincide in IDLE, the snapshot SHALL use the pre-write gains.
REQ-030 ch_in changes after the snapshot SHALL NOT affect the current frame.
REQ-031 With W=OW=8 and NCH=3 at reset gains, the outputs SHALL equal ch0/2 + ch1/4 (left) and ch2/2 + ch1/4 (right), summed before truncation.

Reset
REQ-032 On reset_n=0 the block SHALL asynchronously enter IDLE.
REQ-033 On reset_n=0, audio_l, audio_r, audio_valid, busy, idx, both accumulators and the snapshot SHALL clear to 0.
REQ-034 Gain reset values SHALL be: ch0 GL=8, GR=0; ch1 GL=4, GR=4; ch2 GL=0, GR=8; all other channels 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no audio_valid pulse.
REQ-036 Operation SHALL resume on the first tick after reset_n returns high.

Configuration
REQ-037 With macro AUDIO_MIXER_CLIP_EN defined, the block SHALL add output clip (1 bit).
REQ-038 clip SHALL set sticky when any OUT cycle saturates either side.
REQ-039 clip SHALL clear on any cfg_wr or on reset; if set and clear coincide, set SHALL win.
REQ-040 Without AUDIO_MIXER_CLIP_EN the clip port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-041 Reset defaults, ch_in={ch2=0x80, ch1=0x40, ch0=0xFF}, tick -> audio_valid at edge k+4, audio_l=0x8F, audio_r=0x50.
REQ-042 Saturation: NCH=3, all gains 0xFF, all inputs 0xFF, tick -> audio_l=audio_r=0xFF; clip=1 when the macro is defined.
REQ-043 Overlap: second tick 2 cycles after the first -> exactly one audio_valid pulse; outputs match the first snapshot.
REQ-044 Mid-frame config: cfg_wr addr0 data 0x0F during ACC -> current frame uses GL=8; next frame gives audio_l=ch1/4, audio_r gains ch0*15/16.
REQ-045 Bad address: cfg_wr with cfg_addr=3 (NCH=3) -> gains unchanged and outputs identical to the REQ-041 result.
REQ-046 Reset in ACC cycle 2 -> no audio_valid pulse, outputs 0; next tick gives a correct result.
